// File: rtl/rv64g_pkg.sv
// Shared RV64G core definitions: architectural register count and register index type.
package rv64g_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_lock_cnt.sv
// One per-register in-flight write counter: saturating at MAX_INFL, clamping at zero on underflow.
module reg_lock_cnt #(
    parameter int MAX_INFL = 3,
    parameter int DW       = 2
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clear,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic          nonzero,
    output logic          full,
    output logic          underflow
);

    localparam int CW = $clog2(MAX_INFL + 1);
    localparam int SW = ((CW > DW) ? CW : DW) + 1;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [SW-1:0] total;
    logic [SW-1:0] dec_ext;

    // Issue and write-back in the same cycle cancel; more write-backs than pending clamp to zero.
    always_comb begin
        total     = SW'(cnt_reg) + SW'(inc);
        dec_ext   = SW'(dec);
        underflow = 1'b0;
        cnt_next  = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (dec_ext > total) begin
            cnt_next  = '0;
            underflow = 1'b1;
        end else begin
            cnt_next = CW'(total - dec_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign nonzero = |cnt_reg;
    assign full    = (cnt_reg == CW'(MAX_INFL));

endmodule

// File: rtl/reg_unlock_mgr.sv
// Issue-stage register lock tracker with per-register in-flight counters and a lock-all jump flag.
// Define REG_UNLOCK_MGR_ERR_EN to implement the sticky unlock error flag; otherwise unlock_err_o is 0.
module reg_unlock_mgr
    import rv64g_pkg::*;
#(
    parameter int NUM_WB   = 2,
    parameter int MAX_INFL = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_jump_i,
    input  reg_idx_t              issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [NUM_WB-1:0]     wb_valid_i,
    input  reg_idx_t [NUM_WB-1:0] wb_rd_i,
    input  logic                  jump_done_i,
    input  logic                  flush_i,
    output logic [NUM_REGS-1:0]   locks_o,
    output logic                  unlock_err_o
);

    localparam int NR = NUM_REGS;
    localparam int DW = $clog2(NUM_WB + 1);

    logic          jump_lock_q;
    logic          accept;
    logic [NR-1:0] full_vec;
    logic [NR-1:1] nonzero_vec;
    logic [NR-1:1] underflow_vec;

    // x0 is never tracked, so it can never be full.
    assign full_vec[0]   = 1'b0;
    assign issue_ready_o = ~jump_lock_q &
                           (issue_jump_i | (issue_rd_i == '0) | ~full_vec[issue_rd_i]);
    assign accept        = issue_valid_i & issue_ready_o;
    assign locks_o[0]    = jump_lock_q;

    for (genvar gi = 1; gi < NR; gi++) begin : g_reg
        logic          inc;
        logic [DW-1:0] dec;

        assign inc = accept & ~issue_jump_i & (issue_rd_i == reg_idx_t'(gi));

        // Several write-back ports may retire the same destination in one cycle.
        always_comb begin
            dec = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p] == reg_idx_t'(gi))) begin
                    dec = dec + DW'(1);
                end
            end
        end

        reg_lock_cnt #(
            .MAX_INFL (MAX_INFL),
            .DW       (DW)
        ) u_cnt (
            .clk       (clk_i),
            .srst      (rst_i),
            .clear     (flush_i),
            .inc       (inc),
            .dec       (dec),
            .nonzero   (nonzero_vec[gi]),
            .full      (full_vec[gi]),
            .underflow (underflow_vec[gi])
        );

        assign locks_o[gi] = jump_lock_q | nonzero_vec[gi];
    end

    // A jump cannot be accepted while the lock is held, so set and release never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            jump_lock_q <= 1'b0;
        end else if (flush_i) begin
            jump_lock_q <= 1'b0;
        end else if (accept && issue_jump_i) begin
            jump_lock_q <= 1'b1;
        end else if (jump_done_i) begin
            jump_lock_q <= 1'b0;
        end
    end

`ifdef REG_UNLOCK_MGR_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (!flush_i && (|underflow_vec)) begin
            err_q <= 1'b1;
        end
    end

    assign unlock_err_o = err_q;
`else
    logic unused_underflow;

    assign unused_underflow = |underflow_vec;
    assign unlock_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_unlock_mgr.sv
// Directed self-checking bench for reg_unlock_mgr; honours REG_UNLOCK_MGR_ERR_EN for error expectations.
module tb_reg_unlock_mgr;
    import rv64g_pkg::*;

`ifdef REG_UNLOCK_MGR_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 issue_valid;
    logic                 issue_jump;
    reg_idx_t             issue_rd;
    logic                 issue_ready;
    logic [1:0]           wb_valid;
    reg_idx_t [1:0]       wb_rd;
    logic                 jump_done;
    logic                 flush;
    logic [NUM_REGS-1:0]  locks;
    logic                 unlock_err;

    int tests_run = 0;
    int tests_failed = 0;

    reg_unlock_mgr #(
        .NUM_WB   (2),
        .MAX_INFL (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_jump_i  (issue_jump),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .jump_done_i   (jump_done),
        .flush_i       (flush),
        .locks_o       (locks),
        .unlock_err_o  (unlock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_jump  = 1'b0;
        issue_rd    = '0;
        wb_valid    = '0;
        wb_rd[0]    = '0;
        wb_rd[1]    = '0;
        jump_done   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        #1;
        tests_run++;
        if (locks !== '0) begin
            tests_failed++;
            $display("FAIL reset_locks got=%h exp=%h", locks, 32'h0);
        end
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got=%b exp=1", issue_ready);
        end
        tests_run++;
        if (unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err got=%b exp=0", unlock_err);
        end
        $display("[TB] reset: locks=%h ready=%b err=%b", locks, issue_ready, unlock_err);
    endtask

    task automatic test_rd0_ignored();
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        wb_valid    = 2'b11;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd0_ready got=%b exp=1", issue_ready);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (locks !== '0 || unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd0_nochange got locks=%h err=%b exp locks=0 err=0", locks, unlock_err);
        end
        $display("[TB] rd0: locks=%h err=%b", locks, unlock_err);
    endtask

    task automatic test_lock_unlock();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        idle_inputs();
        tests_run++;
        if (locks[5] !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_t1 got=%b exp=1", locks[5]);
        end
        tick();
        tests_run++;
        if (locks[5] !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_t2 got=%b exp=1", locks[5]);
        end
        wb_valid[0] = 1'b1;
        wb_rd[0]    = 5'd5;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== '0) begin
            tests_failed++;
            $display("FAIL unlock_t3 got=%h exp=%h", locks, 32'h0);
        end
        $display("[TB] lock_unlock rd5: locks=%h", locks);
    endtask

    task automatic test_saturate();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        tick();
        tick();
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_ready_full got=%b exp=0", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        wb_valid[0] = 1'b1;
        wb_rd[0]    = 5'd7;
        tick();
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_ready_after_wb got=%b exp=1", issue_ready);
        end
        tick();
        idle_inputs();
        wb_valid = 2'b11;
        wb_rd[0] = 5'd7;
        wb_rd[1] = 5'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (locks[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_one_left got=%b exp=1", locks[7]);
        end
        wb_valid[0] = 1'b1;
        wb_rd[0]    = 5'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== '0 || unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_drained got locks=%h err=%b exp locks=0 err=0", locks, unlock_err);
        end
        $display("[TB] saturate rd7: locks=%h err=%b", locks, unlock_err);
    endtask

    task automatic test_back_to_back();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        tick();
        wb_valid = 2'b11;
        wb_rd[0] = 5'd9;
        wb_rd[1] = 5'd9;
        tick();
        idle_inputs();
        tests_run++;
        if (locks[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_lock9 got=%b exp=1", locks[9]);
        end
        wb_valid[0] = 1'b1;
        wb_rd[0]    = 5'd9;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== '0 || unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_count1 got locks=%h err=%b exp locks=0 err=0", locks, unlock_err);
        end
        $display("[TB] back_to_back rd9: locks=%h err=%b", locks, unlock_err);
    endtask

    task automatic test_jump();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_jump = 1'b1;
        issue_rd   = 5'd0;
        tick();
        issue_jump = 1'b0;
        issue_rd   = 5'd10;
        #1;
        tests_run++;
        if (locks !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL jump_all_locked got=%h exp=%h", locks, 32'hFFFF_FFFF);
        end
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump_ready got=%b exp=0", issue_ready);
        end
        tick();
        jump_done = 1'b1;
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump_ready_done_cycle got=%b exp=0", issue_ready);
        end
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== 32'h0000_0008) begin
            tests_failed++;
            $display("FAIL jump_released got=%h exp=%h", locks, 32'h0000_0008);
        end
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump_ready_after got=%b exp=1", issue_ready);
        end
        wb_valid[1] = 1'b1;
        wb_rd[1]    = 5'd3;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== '0 || unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump_cleanup got locks=%h err=%b exp locks=0 err=0", locks, unlock_err);
        end
        $display("[TB] jump: locks=%h ready=%b", locks, issue_ready);
    endtask

    task automatic test_flush();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        tick();
        issue_rd = 5'd12;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== 32'h0000_1010) begin
            tests_failed++;
            $display("FAIL flush_pre got=%h exp=%h", locks, 32'h0000_1010);
        end
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        tick();
        idle_inputs();
        tests_run++;
        if (locks !== '0 || unlock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear got locks=%h err=%b exp locks=0 err=0", locks, unlock_err);
        end
        wb_valid[0] = 1'b1;
        wb_rd[0]    = 5'd4;
        tick();
        idle_inputs();
        tests_run++;
        if (unlock_err !== ERR_EN) begin
            tests_failed++;
            $display("FAIL flush_err_set got=%b exp=%b", unlock_err, ERR_EN);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (unlock_err !== ERR_EN) begin
            tests_failed++;
            $display("FAIL flush_err_sticky got=%b exp=%b", unlock_err, ERR_EN);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (unlock_err !== 1'b0 || locks !== '0) begin
            tests_failed++;
            $display("FAIL flush_err_rst got err=%b locks=%h exp err=0 locks=0", unlock_err, locks);
        end
        $display("[TB] flush: locks=%h err=%b", locks, unlock_err);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_rd0_ignored();
        test_lock_unlock();
        test_saturate();
        test_back_to_back();
        test_jump();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_unlock_mgr.md
# reg_unlock_mgr

Holds the register lock state of the issue stage and releases locks as results retire. It is the counterpart of the issue-side grant checker: that checker consumes `locks_o` as its lock input and requests new locks; this block stores them and clears them on write-back, jump resolution or flush. Per-register in-flight counters allow several outstanding writes to the same destination.

## Interface
Parameters:
- `NR`, `rv64g_pkg::NUM_REGS` (localparam): number of architectural registers.
- `NUM_WB`, 2: number of write-back unlock ports.
- `MAX_INFL`, 3: maximum outstanding writes per register.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `issue_valid_i`  in  1  an instruction is presented for lock.
- `issue_jump_i`  in  1  the presented instruction is a jump; lock all registers.
- `issue_rd_i`  in  `$clog2(NR)`  destination register of the presented instruction.
- `issue_ready_o`  out  1  a lock can be accepted this cycle.
- `wb_valid_i`  in  `NUM_WB`  per-port write-back unlock strobe.
- `wb_rd_i`  in  `NUM_WB` x `$clog2(NR)`  per-port unlocked register index.
- `jump_done_i`  in  1  the outstanding jump has resolved; release the lock-all.
- `flush_i`  in  1  pipeline flush; clear all lock state.
- `locks_o`  out  `NR`  current locked-register vector.
- `unlock_err_o`  out  1  sticky flag: a write-back to an unlocked register was seen.

## Operation
- State: `cnt[r]` for r=1..NR-1, width `$clog2(MAX_INFL+1)`, plus the `jump_lock_q` and `err_q` flops. x0 has no counter.
- `locks_o[r] = jump_lock_q | (cnt[r] != 0)`. `locks_o[0] = jump_lock_q`.
- `issue_ready_o = ~jump_lock_q & (issue_jump_i | issue_rd_i == 0 | cnt[issue_rd_i] != MAX_INFL)`. It is combinational on the registered state and the issue inputs.
- Accept is `issue_valid_i & issue_ready_o`:
  - Jump: set `jump_lock_q`.
  - Non-jump with rd ≠ 0: increment that register's count.
  - rd = 0: no state change.
- Write-back: each valid port with rd ≠ 0 decrements that register's count by 1. Ports naming the same rd in one cycle decrement by the number of such ports. Ports with rd = 0 are ignored.
- Net update per register: `cnt + inc - dec`, where inc is 0/1 and dec is 0..NUM_WB. An accepted issue and a write-back to the same rd in the same cycle cancel.
- Underflow: if dec exceeds `cnt + inc`, clamp to 0 and set `err_q`. `err_q` is cleared only by `rst_i`.
- `jump_done_i` clears `jump_lock_q`. Per-register counts are unaffected. `jump_done_i` while `jump_lock_q = 0` is ignored.
- `flush_i` clears all counts and `jump_lock_q`. It takes priority over same-cycle issue, write-back and `jump_done_i`. It does not clear `err_q` and never sets it.
- `rst_i` has priority over everything.

## Timing
- Reset values: `locks_o` = 0, `unlock_err_o` = 0, `issue_ready_o` = 1 (all registers are free and there is no jump lock).
- Lock latency: an issue accepted in cycle t appears in `locks_o` in cycle t+1.
- Unlock latency: a write-back in cycle t clears the lock in cycle t+1, provided the count reaches 0.
- `unlock_err_o` asserts in the cycle after the offending write-back.
- `jump_lock_q` set in cycle t blocks issue from cycle t+1 until the cycle after `jump_done_i`.
- If `rst_i` is asserted mid-operation, all state is zero in the next cycle. In-flight write-backs that arrive after reset produce `unlock_err_o`; this is intended.

## Configuration
- `REG_UNLOCK_MGR_ERR_EN` defined: `err_q` is implemented and `unlock_err_o` behaves as specified above.
- `REG_UNLOCK_MGR_ERR_EN` undefined: there is no `err_q` flop and `unlock_err_o` is tied to 0. Underflow still clamps to 0, silently.

## Structure
- `rv64g_pkg` holds `NUM_REGS`.
- `rv64g_pkg` also gets a new typedef `reg_idx_t` (`logic [$clog2(NUM_REGS)-1:0]`), used for `issue_rd_i` and `wb_rd_i`.
- Sub-module `reg_lock_cnt`: one saturating up/down counter.
  - Inputs: inc, dec count, clear.
  - Outputs: nonzero, full, underflow.
  - Instantiated NR-1 times in a generate loop.
- Top level contains the write-back port decoders, the jump flop, the error flop and the ready logic.

## Test plan
- Reset, then idle → `locks_o` = 0, `issue_ready_o` = 1, `unlock_err_o` = 0.
- Issue rd=5, then 2 cycles later wb port0 rd=5 → `locks_o[5]` = 1 for cycles t+1..t+2, back to 0 at t+3.
- Issue rd=7 three times, then present rd=7 again → `issue_ready_o` = 0. One wb rd=7 → ready = 1 next cycle. Three further wbs → `locks_o[7]` = 0.
- Count of rd=9 is 2. Same cycle: issue rd=9 plus wb port0 rd=9 and port1 rd=9 → count becomes 1 and `locks_o[9]` stays 1.
- Issue jump → `locks_o` all 1s and `issue_ready_o` = 0. Assert `jump_done_i` → next cycle `locks_o` shows only the per-register counts, e.g. bit 3 if rd=3 was pending.
- Locks held on rd=4 and rd=12, then `flush_i` with a same-cycle issue rd=6 → `locks_o` = 0 next cycle. Afterwards wb rd=4 → `unlock_err_o` = 1 and stays 1 until `rst_i`; it stays 0 when `REG_UNLOCK_MGR_ERR_EN` is undefined.
